cpu_run_controller: RTL and testbench

- Debug/run sequencer for the single-cycle MIPS core.
- Loads program words into instruction memory through a valid/ready stream, holds the core in reset while loading, then runs it, single-steps it or halts it.
- Halts on a PC breakpoint or on a branch-to-self loop, and counts executed cycles.
- Sits between the host/testbench command interface and the core's clock-enable, reset and instruction-memory write port.

---
 rtl/cpu_ctrl_pkg.sv | 37 +++
 rtl/imem_loader.sv | 81 ++++++++
 rtl/cpu_run_controller.sv | 190 +++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the MIPS core run controller.
package cpu_ctrl_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRun    = 3'd2,
    StStep   = 3'd3,
    StHalted = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OpNop       = 3'd0,
    OpLoad      = 3'd1,
    OpRun       = 3'd2,
    OpStep      = 3'd3,
    OpHalt      = 3'd4,
    OpSetBp     = 3'd5,
    OpClrBp     = 3'd6,
    OpResetCore = 3'd7
  } cmd_op_t;

  typedef enum logic [2:0] {
    HcNone     = 3'd0,
    HcCmd      = 3'd1,
    HcBp       = 3'd2,
    HcLoop     = 3'd3,
    HcStepDone = 3'd4
  } halt_cause_t;

  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Program-load stream: accepts cnt words and issues one registered imem write per handshake.
module imem_loader
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CntW = 7
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [CntW-1:0] cnt_i,
  input  logic            load_valid_i,
  output logic            load_ready_o,
  input  logic [31:0]     load_data_i,
  output logic            imem_we_o,
  output logic [31:0]     imem_waddr_o,
  output logic [31:0]     imem_wdata_o,
  output logic            done_o
);

  logic            busy_q, busy_d;
  logic [CntW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            hs;
  logic            last;

  always_comb begin
    hs      = busy_q & load_valid_i;
    last    = hs && ((idx_q + CntW'(1)) == cnt_q);
    busy_d  = busy_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = hs;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // done lines up with the cycle that shows the final write
    done_d  = last;
    if (start_i) begin
      busy_d = 1'b1;
      idx_d  = '0;
      cnt_d  = cnt_i;
    end else if (hs) begin
      idx_d   = idx_q + CntW'(1);
      waddr_d = word_addr(32'(idx_q));
      wdata_d = load_data_i;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign load_ready_o = busy_q;
  assign imem_we_o    = we_q;
  assign imem_waddr_o = waddr_q;
  assign imem_wdata_o = wdata_q;
  assign done_o       = done_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Debug/run sequencer: loads imem, then runs, steps or halts the core with breakpoint,
// branch-to-self detection and an executed-cycle counter.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned CYC_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [31:0]      load_data,
  output logic             imem_we,
  output logic [31:0]      imem_waddr,
  output logic [31:0]      imem_wdata,
  input  logic [31:0]      pc,
  input  logic [31:0]      next_pc,
  output logic             core_rst,
  output logic             core_en,
  output logic [2:0]       state,
  output logic [2:0]       halt_cause,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned CntW = $clog2(IMEM_DEPTH + 1);

  state_t            state_q, state_d;
  halt_cause_t       halt_cause_q, halt_cause_d;
  logic              core_rst_q, core_rst_d;
  logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
  logic              bp_en_q, bp_en_d;
  logic [31:0]       bp_addr_q, bp_addr_d;
  logic              bp_skip_q, bp_skip_d;
  logic [31:0]       step_cnt_q, step_cnt_d;

  cmd_op_t           op;
  logic              cmd_fire;
  logic              running;
  logic              bp_block;
  logic              core_en_c;
  logic [CntW-1:0]   load_cnt;
  logic              load_start;
  logic              load_done;

  always_comb begin
    cmd_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StHalted);
    cmd_fire  = cmd_valid & cmd_ready;
    op        = cmd_op_t'(cmd_op);
    running   = (state_q == StRun) || (state_q == StStep);
    bp_block  = bp_en_q && (pc == bp_addr_q) && !bp_skip_q;
    // Combinational gate so a breakpointed instruction never commits
    core_en_c = running && !bp_block;
    load_cnt  = (cmd_data > 32'(IMEM_DEPTH)) ? CntW'(IMEM_DEPTH) : cmd_data[CntW-1:0];
  end

  always_comb begin
    state_d       = state_q;
    halt_cause_d  = halt_cause_q;
    core_rst_d    = core_rst_q;
    cycle_count_d = cycle_count_q;
    bp_en_d       = bp_en_q;
    bp_addr_d     = bp_addr_q;
    bp_skip_d     = bp_skip_q;
    step_cnt_d    = step_cnt_q;
    load_start    = 1'b0;

    if (core_en_c && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CYC_W'(1);
    end

    if (cmd_fire && (op == OpSetBp)) begin
      bp_addr_d = cmd_data;
      bp_en_d   = 1'b1;
    end
    if (cmd_fire && (op == OpClrBp)) begin
      bp_en_d = 1'b0;
    end

    unique case (state_q)
      StIdle, StHalted: begin
        if (cmd_fire) begin
          case (op)
            OpLoad: begin
              if (load_cnt != '0) begin
                load_start = 1'b1;
                state_d    = StLoad;
                core_rst_d = 1'b1;
              end
            end
            OpRun, OpStep: begin
              state_d      = (op == OpRun) ? StRun : StStep;
              core_rst_d   = 1'b0;
              halt_cause_d = HcNone;
              // Resuming from a breakpoint lets that instruction through once
              bp_skip_d    = (state_q == StHalted) && (halt_cause_q == HcBp);
              if (op == OpStep) begin
                step_cnt_d = (cmd_data == '0) ? 32'd1 : cmd_data;
              end
            end
            OpResetCore: begin
              state_d       = StIdle;
              core_rst_d    = 1'b1;
              cycle_count_d = '0;
              halt_cause_d  = HcNone;
              bp_skip_d     = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StLoad: begin
        if (load_done) begin
          state_d = StIdle;
        end
      end
      StRun, StStep: begin
        if (core_en_c) begin
          bp_skip_d = 1'b0;
          if (state_q == StStep) begin
            step_cnt_d = step_cnt_q - 32'd1;
          end
        end
        if (bp_block) begin
          state_d      = StHalted;
          halt_cause_d = HcBp;
        end else if (next_pc == pc) begin
          state_d      = StHalted;
          halt_cause_d = HcLoop;
        end else if ((state_q == StStep) && (step_cnt_q == 32'd1)) begin
          state_d      = StHalted;
          halt_cause_d = HcStepDone;
        end else if ((state_q == StRun) && cmd_fire && (op == OpHalt)) begin
          state_d      = StHalted;
          halt_cause_d = HcCmd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      halt_cause_q  <= HcNone;
      core_rst_q    <= 1'b1;
      cycle_count_q <= '0;
      bp_en_q       <= 1'b0;
      bp_addr_q     <= '0;
      bp_skip_q     <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      halt_cause_q  <= halt_cause_d;
      core_rst_q    <= core_rst_d;
      cycle_count_q <= cycle_count_d;
      bp_en_q       <= bp_en_d;
      bp_addr_q     <= bp_addr_d;
      bp_skip_q     <= bp_skip_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  imem_loader #(
    .CntW(CntW)
  ) u_loader (
    .clk_i        (clk),
    .rst_ni       (reset),
    .start_i      (load_start),
    .cnt_i        (load_cnt),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_data_i  (load_data),
    .imem_we_o    (imem_we),
    .imem_waddr_o (imem_waddr),
    .imem_wdata_o (imem_wdata),
    .done_o       (load_done)
  );

  assign state       = state_q;
  assign halt_cause  = halt_cause_q;
  assign core_rst    = core_rst_q;
  assign core_en     = core_en_c;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a toy straight-line core with a branch-to-self at loop_addr,
// and an instruction-level model predicting every run, step and load.
module tb_cpu_run_controller;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4, OP_SET_BP = 3'd5, OP_CLR_BP = 3'd6, OP_RST = 3'd7;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        load_valid, load_ready;
  logic [31:0] load_data;
  logic        imem_we;
  logic [31:0] imem_waddr, imem_wdata;
  logic [31:0] pc, next_pc;
  logic        core_rst, core_en;
  logic [2:0]  state, halt_cause;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] loop_addr;
  bit          bp_en_ref;
  logic [31:0] bp_addr_ref, pc_ref, cyc_ref;
  bit          in_halted;
  logic [2:0]  last_cause;
  logic [2:0]  ign [5];

  cpu_run_controller #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .CYC_W     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .next_pc    (next_pc),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .state      (state),
    .halt_cause (halt_cause),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy core: straight-line code, except a branch-to-self at loop_addr
  assign next_pc = (pc == loop_addr) ? pc : pc + 32'd4;
  always @(posedge clk) begin
    if (core_rst) pc <= 32'd0;
    else if (core_en) pc <= next_pc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level prediction of one RUN/STEP: executed count, cause and final pc.
  function automatic void predict(input logic [31:0] start, input bit is_step, input int n,
                                  input bit skip, input int halt_at, output int e,
                                  output logic [2:0] cause, output logic [31:0] fpc);
    logic [31:0] p;
    bit sk;
    int nn;
    p = start;
    sk = skip;
    nn = (n == 0) ? 1 : n;
    e = 0;
    cause = 3'd0;
    for (int g = 0; g < 1000; g++) begin
      if (bp_en_ref && p == bp_addr_ref && !sk) begin cause = 3'd2; break; end
      e++;
      sk = 1'b0;
      if (p == loop_addr) begin cause = 3'd3; break; end
      p += 32'd4;
      if (is_step && e == nn) begin cause = 3'd4; break; end
      if (halt_at == e) begin cause = 3'd1; break; end
    end
    fpc = p;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] data);
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
  endtask

  task automatic do_load(input int req, input logic [31:0] vpat);
    int cnt, hs, writes;
    bit pend;
    logic [31:0] pa, pd, last_a;
    cnt = (req > int'(IMEM_DEPTH)) ? int'(IMEM_DEPTH) : req;
    issue(OP_LOAD, 32'(req));
    if (cnt == 0) begin
      chk("ld0_state", 32'(state), in_halted ? 32'd4 : 32'd0);
      chk("ld0_ready", 32'(load_ready), 32'd0);
      chk("ld0_we", 32'(imem_we), 32'd0);
      return;
    end
    pc_ref = 32'd0;
    in_halted = 1'b0;
    hs = 0; writes = 0; pend = 1'b0; pa = '0; pd = '0; last_a = '0;
    for (int c = 0; c < 400; c++) begin
      chk("ld_we", 32'(imem_we), 32'(pend));
      if (pend) begin
        chk("ld_addr", imem_waddr, pa);
        chk("ld_data", imem_wdata, pd);
        writes++;
        last_a = pa;
      end
      chk("ld_core_rst", 32'(core_rst), 32'd1);
      chk("ld_core_en", 32'(core_en), 32'd0);
      if (hs < cnt) chk("ld_state", 32'(state), 32'd1);
      chk("ld_ready", 32'(load_ready), 32'(hs < cnt));
      if (pend && hs == cnt) break;
      load_valid = (c < 32) ? vpat[c] : 1'b1;
      load_data = $urandom;
      pend = load_valid && (hs < cnt);
      if (pend) begin
        pa = 32'(hs * 4);
        pd = load_data;
        hs++;
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    chk("ld_writes", 32'(writes), 32'(cnt));
    chk("ld_last_addr", last_a, 32'((cnt - 1) * 4));
    for (int k = 0; k < 3; k++) begin
      if (state == 3'd0) break;
      @(posedge clk); #1;
    end
    chk("ld_end_state", 32'(state), 32'd0);
    chk("ld_end_we", 32'(imem_we), 32'd0);
  endtask

  task automatic do_run(input bit is_step, input int n, input int halt_at,
                        input logic [2:0] side_op);
    int e, r;
    logic [2:0] cause;
    logic [31:0] fpc;
    bit skip;
    skip = in_halted && (last_cause == 3'd2);
    predict(pc_ref, is_step, n, skip, (side_op == OP_HALT) ? halt_at : 0, e, cause, fpc);
    r = e + ((cause == 3'd2) ? 1 : 0);
    issue(is_step ? OP_STEP : OP_RUN, 32'(n));
    for (int j = 1; j <= r; j++) begin
      if (j == 1) chk("run_cause_clr", 32'(halt_cause), 32'd0);
      chk("run_state", 32'(state), is_step ? 32'd3 : 32'd2);
      chk("run_core_en", 32'(core_en), 32'(j <= e));
      chk("run_core_rst", 32'(core_rst), 32'd0);
      if (!is_step && halt_at == j) begin
        chk("run_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = side_op;
        cmd_data = $urandom;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op = OP_NOP;
    end
    cyc_ref = cyc_ref + 32'(e);
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_core_en", 32'(core_en), 32'd0);
    chk("halt_cause", 32'(halt_cause), 32'(cause));
    chk("halt_cycles", cycle_count, cyc_ref);
    chk("halt_pc", pc, fpc);
    pc_ref = fpc;
    in_halted = 1'b1;
    last_cause = cause;
  endtask

  task automatic set_bp(input logic [31:0] a);
    issue(OP_SET_BP, a);
    bp_en_ref = 1'b1;
    bp_addr_ref = a;
    chk("setbp_state", 32'(state), in_halted ? 32'd4 : 32'd0);
  endtask

  task automatic clr_bp();
    issue(OP_CLR_BP, 32'd0);
    bp_en_ref = 1'b0;
    chk("clrbp_state", 32'(state), in_halted ? 32'd4 : 32'd0);
  endtask

  task automatic reset_core();
    issue(OP_RST, 32'd0);
    chk("rc_state", 32'(state), 32'd0);
    chk("rc_core_rst", 32'(core_rst), 32'd1);
    chk("rc_cycles", cycle_count, 32'd0);
    chk("rc_cause", 32'(halt_cause), 32'd0);
    cyc_ref = 32'd0;
    pc_ref = 32'd0;
    in_halted = 1'b0;
    last_cause = 3'd0;
  endtask

  initial begin
    ign = '{OP_NOP, OP_LOAD, OP_RUN, OP_STEP, OP_RST};
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
    load_valid = 1'b0; load_data = '0;
    loop_addr = 32'h40;
    bp_en_ref = 1'b0; bp_addr_ref = '0; pc_ref = '0; cyc_ref = '0;
    in_halted = 1'b0; last_cause = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_load(3, 32'hFFFF_FFFD);   // bubble after the first word
    do_load(100, $urandom);      // clamps to IMEM_DEPTH
    do_load(0, 32'hFFFF_FFFF);

    set_bp(32'h8);
    do_run(1'b0, 0, 0, OP_NOP);  // stops at 0x8 after 2 cycles
    do_run(1'b0, 0, 0, OP_NOP);  // passes 0x8 once, runs to the loop

    clr_bp();
    reset_core();
    loop_addr = 32'hC;
    do_run(1'b0, 0, 0, OP_NOP);

    reset_core();
    loop_addr = 32'h100;
    do_run(1'b1, 2, 0, OP_NOP);
    do_run(1'b1, 0, 0, OP_NOP);

    set_bp(32'h10);
    do_run(1'b0, 0, 2, OP_HALT); // HALT lands on the breakpoint cycle
    do_run(1'b0, 0, 3, OP_HALT);

    reset_core();
    loop_addr = 32'h30;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: do_run(1'b0, 0, int'($urandom_range(0, 12)),
                  ($urandom_range(0, 2) != 0) ? OP_HALT : ign[$urandom_range(0, 4)]);
        1: do_run(1'b1, int'($urandom_range(0, 4)), 0, OP_NOP);
        2: set_bp(32'($urandom_range(0, 16) * 4));
        3: clr_bp();
        4: begin
          reset_core();
          loop_addr = 32'($urandom_range(3, 20) * 4);
        end
        default: do_load(int'($urandom_range(0, 5)), $urandom);
      endcase
    end

    // Asynchronous abort in the middle of a load
    issue(OP_LOAD, 32'd10);
    load_valid = 1'b1;
    load_data = $urandom;
    @(posedge clk); #1;
    chk("abort_we_before", 32'(imem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(imem_we), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_cycles", cycle_count, 32'd0);
    chk("abort_load_ready", 32'(load_ready), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    load_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
